fetch_unit: RTL and testbench

Instruction fetch stage of the CPU. Sits directly upstream of decode and drives the instruction ROM port (`rom_chip_enable`, `rom_address`, `rom_data`). It holds the program counter and issues sequential word fetches. Fetched words are buffered with their PCs in a small FIFO and handed to decode over a valid/ready handshake. Branch redirects flush the FIFO.

---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, combinational ROM read, and a small
// {pc, inst} queue handed to decode over valid/ready. Branches flush the queue.
module fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        rom_chip_enable,
   output logic [31:0] rom_address,
   input  logic [31:0] rom_data,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [31:0]   mem_pc_q   [DEPTH];
   logic [31:0]   mem_pc_d   [DEPTH];
   logic [31:0]   mem_inst_q [DEPTH];
   logic [31:0]   mem_inst_d [DEPTH];
   logic          enq;
   logic          deq;

   // Fetching is gated by reset itself so the ROM is idle while held in reset.
   assign enq             = reset && (count_q < FULL) && !branch_valid;
   assign deq             = inst_valid && inst_ready;
   assign rom_chip_enable = enq;
   assign rom_address     = pc_q;
   assign inst_valid      = (count_q != '0);
   assign inst            = inst_valid ? mem_inst_q[rd_ptr_q] : '0;
   assign inst_pc         = inst_valid ? mem_pc_q[rd_ptr_q]   : '0;

   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (branch_valid) begin
         pc_d     = {branch_target[31:2], 2'b00};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + (PW + 1)'(enq) - (PW + 1)'(deq);
      end
   end

   always_comb begin
      mem_pc_d   = mem_pc_q;
      mem_inst_d = mem_inst_q;
      if (enq) begin
         mem_pc_d[wr_ptr_q]   = pc_q;
         mem_inst_d[wr_ptr_q] = rom_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage is deliberately left out of reset; count gates its visibility.
   always_ff @(posedge clock) begin
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected {pc, inst}
// pairs, and negedge monitors pop and compare on every decode handshake.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic        inst_ready;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        rom_chip_enable;
   logic [31:0] rom_address;
   logic [31:0] rom_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   logic        wrap_ready;
   logic        wrap_branch_valid;
   logic [31:0] wrap_branch_target;
   logic        wrap_rom_chip_enable;
   logic [31:0] wrap_rom_address;
   logic [31:0] wrap_rom_data;
   logic        wrap_inst_valid;
   logic [31:0] wrap_inst;
   logic [31:0] wrap_inst_pc;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] wrap_exp_q[$];

   // ROM word i holds the value i.
   assign rom_data      = {2'b00, rom_address[31:2]};
   assign wrap_rom_data = {2'b00, wrap_rom_address[31:2]};

   fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset(reset),
      .rom_chip_enable(rom_chip_enable), .rom_address(rom_address), .rom_data(rom_data),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clock(clock), .reset(reset),
      .rom_chip_enable(wrap_rom_chip_enable), .rom_address(wrap_rom_address),
      .rom_data(wrap_rom_data),
      .branch_valid(wrap_branch_valid), .branch_target(wrap_branch_target),
      .inst_valid(wrap_inst_valid), .inst(wrap_inst), .inst_pc(wrap_inst_pc),
      .inst_ready(wrap_ready)
   );

   initial clock = 0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input logic [31:0] pc);
      exp_q.push_back({pc, 2'b00, pc[31:2]});
   endtask

   // Drives one cycle's inputs just after the edge, then waits to the sampling point.
   task automatic applyStimulus(input logic rdy, input logic bv, input logic [31:0] bt);
      inst_ready    = rdy;
      branch_valid  = bv;
      branch_target = bt;
      @(negedge clock);
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic resetDut();
      #2 reset = 0;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1;
   endtask

   always @(negedge clock) begin
      if (reset && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("mon_unexpected_pc", inst_pc, 32'hDEAD_BEEF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            checkOutput("mon_pc", inst_pc, e[63:32]);
            checkOutput("mon_inst", inst, e[31:0]);
         end
      end
   end

   always @(negedge clock) begin
      if (reset && wrap_inst_valid && wrap_ready) begin
         if (wrap_exp_q.size() == 0) begin
            checkOutput("wrap_unexpected_pc", wrap_inst_pc, 32'hDEAD_BEEF);
         end else begin
            logic [63:0] e;
            e = wrap_exp_q.pop_front();
            checkOutput("wrap_pc", wrap_inst_pc, e[63:32]);
            checkOutput("wrap_inst", wrap_inst, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1;
      inst_ready = 0;
      branch_valid = 0;
      branch_target = '0;
      wrap_ready = 0;
      wrap_branch_valid = 0;
      wrap_branch_target = '0;

      #2 reset = 0;
      #1;
      checkOutput("rst_ce", 32'(rom_chip_enable), 32'd0);
      checkOutput("rst_addr", rom_address, 32'h0);
      checkOutput("rst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
      checkOutput("rst_wrap_addr", wrap_rom_address, 32'hFFFF_FFF8);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1;

      $display("[TB] streaming");
      applyStimulus(1, 0, '0);
      checkOutput("c0_ce", 32'(rom_chip_enable), 32'd1);
      checkOutput("c0_addr", rom_address, 32'h0);
      checkOutput("c0_valid", 32'(inst_valid), 32'd0);
      for (int k = 0; k < 8; k++) pushExp(32'(k * 4));
      for (int c = 1; c <= 8; c++) begin
         nextCycle();
         applyStimulus(1, 0, '0);
         checkOutput("stream_valid", 32'(inst_valid), 32'd1);
      end
      nextCycle();
      applyStimulus(0, 0, '0);
      checkOutput("stream_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] backpressure");
      resetDut();
      for (int c = 0; c < 6; c++) begin
         applyStimulus(0, 0, '0);
         if (c >= 4) begin
            checkOutput("bp_ce", 32'(rom_chip_enable), 32'd0);
            checkOutput("bp_addr", rom_address, 32'h10);
            checkOutput("bp_head_pc", inst_pc, 32'h0);
         end
         nextCycle();
      end
      for (int k = 0; k < 10; k++) pushExp(32'(k * 4));
      for (int c = 6; c < 16; c++) begin
         applyStimulus(1, 0, '0);
         checkOutput("bp_valid", 32'(inst_valid), 32'd1);
         nextCycle();
      end
      applyStimulus(0, 0, '0);
      checkOutput("bp_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] branch");
      resetDut();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 0, '0);
         nextCycle();
      end
      pushExp(32'h0);
      applyStimulus(1, 1, 32'h100);
      checkOutput("br_ce", 32'(rom_chip_enable), 32'd0);
      nextCycle();
      applyStimulus(1, 0, '0);
      checkOutput("br_valid", 32'(inst_valid), 32'd0);
      checkOutput("br_addr", rom_address, 32'h100);
      checkOutput("br_ce_resume", 32'(rom_chip_enable), 32'd1);
      nextCycle();
      pushExp(32'h100);
      pushExp(32'h104);
      pushExp(32'h108);
      applyStimulus(1, 0, '0);
      checkOutput("br_target_pc", inst_pc, 32'h100);
      nextCycle();
      applyStimulus(1, 0, '0);
      nextCycle();
      applyStimulus(1, 1, 32'h103);
      nextCycle();
      applyStimulus(1, 1, 32'h200);
      checkOutput("mis_addr", rom_address, 32'h100);
      checkOutput("b2b_valid", 32'(inst_valid), 32'd0);
      checkOutput("b2b_ce", 32'(rom_chip_enable), 32'd0);
      nextCycle();
      applyStimulus(1, 0, '0);
      checkOutput("b2b_addr", rom_address, 32'h200);
      checkOutput("b2b_empty", 32'(inst_valid), 32'd0);
      nextCycle();
      pushExp(32'h200);
      applyStimulus(1, 0, '0);
      checkOutput("b2b_target_pc", inst_pc, 32'h200);
      nextCycle();
      applyStimulus(0, 0, '0);
      checkOutput("br_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] mid-stream reset");
      resetDut();
      pushExp(32'h0);
      pushExp(32'h4);
      pushExp(32'h8);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1, 0, '0);
         nextCycle();
      end
      applyStimulus(1, 0, '0);
      #2 reset = 0;
      #1;
      checkOutput("mid_valid", 32'(inst_valid), 32'd0);
      checkOutput("mid_ce", 32'(rom_chip_enable), 32'd0);
      checkOutput("mid_addr", rom_address, 32'h0);
      checkOutput("mid_inst_pc", inst_pc, 32'h0);
      checkOutput("mid_drain", 32'(exp_q.size()), 32'd0);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1;
      for (int k = 0; k < 4; k++) pushExp(32'(k * 4));
      applyStimulus(1, 0, '0);
      checkOutput("mid_restart_valid", 32'(inst_valid), 32'd0);
      checkOutput("mid_restart_addr", rom_address, 32'h0);
      nextCycle();
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(1, 0, '0);
         nextCycle();
      end
      applyStimulus(0, 0, '0);
      checkOutput("mid_restart_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] pc wrap");
      resetDut();
      wrap_exp_q.push_back({32'hFFFF_FFF8, 32'h3FFF_FFFE});
      wrap_exp_q.push_back({32'hFFFF_FFFC, 32'h3FFF_FFFF});
      wrap_exp_q.push_back({32'h0000_0000, 32'h0000_0000});
      wrap_ready = 1;
      applyStimulus(0, 0, '0);
      checkOutput("wrap_c0_addr", wrap_rom_address, 32'hFFFF_FFF8);
      nextCycle();
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(0, 0, '0);
         nextCycle();
      end
      wrap_ready = 0;
      applyStimulus(0, 0, '0);
      checkOutput("wrap_drain", 32'(wrap_exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
